// File: rtl/sum_differencer.sv
// Recovers addends from a stream of signed running sums: d[n] = s[n] - s[n-1].
// Flags borrow/signed overflow per sample; halts on overflow until clear or reset.
module sum_differencer #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 8,
  parameter int PRIME_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic [WIDTH-1:0] prev,
  output logic             borrow,
  output logic             overflow,
  output logic             halted,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {PRIME, RUN, HALT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_d_out;
  logic             r_d_valid;
  logic [WIDTH-1:0] r_prev;
  logic             r_borrow;
  logic             r_overflow;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH:0]   w_diff;
  logic             w_ovf;
  logic             w_cnt_sat;
  logic             w_emit;

  // prev is always zero in PRIME (reset/clear zero it), so one subtractor serves both states.
  assign w_diff    = {1'b0, sum_in} - {1'b0, r_prev};
  assign w_ovf     = (r_prev[WIDTH-1] != sum_in[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != sum_in[WIDTH-1]);
  assign w_cnt_sat = (r_count == {CNT_W{1'b1}});
  assign w_emit    = in_valid && ((r_state == RUN) ||
                                  ((r_state == PRIME) && (PRIME_ZERO != 0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= PRIME;
      r_d_out    <= '0;
      r_d_valid  <= 1'b0;
      r_prev     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else if (clear) begin
      r_state    <= PRIME;
      r_d_valid  <= 1'b0;
      r_prev     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      r_d_valid <= 1'b0;
      if (w_emit) begin
        r_d_out    <= w_diff[WIDTH-1:0];
        r_borrow   <= w_diff[WIDTH];
        r_overflow <= w_ovf;
        r_d_valid  <= 1'b1;
        r_prev     <= sum_in;
        if (!w_cnt_sat) r_count <= r_count + 1'b1;
        r_state    <= w_ovf ? HALT : RUN;
      end else if (in_valid && (r_state == PRIME)) begin
        // Non-priming variant: first sample only seeds the reference.
        r_prev  <= sum_in;
        r_state <= RUN;
      end
    end
  end

  assign d_out    = r_d_out;
  assign d_valid  = r_d_valid;
  assign prev     = r_prev;
  assign borrow   = r_borrow;
  assign overflow = r_overflow;
  assign halted   = (r_state == HALT);
  assign count    = r_count;

endmodule

// File: tb/tb_sum_differencer.sv
// Directed bench: three configurations share stimulus; expectations hand-computed.
module tb_sum_differencer;

  logic       gclk;
  logic       grst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] sum_in;

  logic [7:0] a_d, b_d, c_d;
  logic       a_dv, b_dv, c_dv;
  logic [7:0] a_prev, b_prev, c_prev;
  logic       a_brw, b_brw, c_brw;
  logic       a_ovf, b_ovf, c_ovf;
  logic       a_hlt, b_hlt, c_hlt;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;

  int checks   = 0;
  int failures = 0;

  sum_differencer #(.WIDTH(8), .CNT_W(8), .PRIME_ZERO(1)) u_pz1 (
    .clk(gclk), .rst(grst_n), .clear(clear), .in_valid(in_valid), .sum_in(sum_in),
    .d_out(a_d), .d_valid(a_dv), .prev(a_prev), .borrow(a_brw), .overflow(a_ovf),
    .halted(a_hlt), .count(a_cnt));

  sum_differencer #(.WIDTH(8), .CNT_W(8), .PRIME_ZERO(0)) u_pz0 (
    .clk(gclk), .rst(grst_n), .clear(clear), .in_valid(in_valid), .sum_in(sum_in),
    .d_out(b_d), .d_valid(b_dv), .prev(b_prev), .borrow(b_brw), .overflow(b_ovf),
    .halted(b_hlt), .count(b_cnt));

  sum_differencer #(.WIDTH(8), .CNT_W(2), .PRIME_ZERO(1)) u_c2 (
    .clk(gclk), .rst(grst_n), .clear(clear), .in_valid(in_valid), .sum_in(sum_in),
    .d_out(c_d), .d_valid(c_dv), .prev(c_prev), .borrow(c_brw), .overflow(c_ovf),
    .halted(c_hlt), .count(c_cnt));

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] s);
    in_valid = v;
    sum_in   = s;
    step();
  endtask

  task automatic do_reset();
    @(posedge gclk);
    #1;
    grst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; sum_in = '0;
    @(negedge gclk);
    grst_n = 1'b1;
    step();
  endtask

  initial begin
    grst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; sum_in = '0;
    do_reset();

    // Reset state
    chk("rst_d", a_d, 0);       chk("rst_dv", a_dv, 0);  chk("rst_prev", a_prev, 0);
    chk("rst_brw", a_brw, 0);   chk("rst_ovf", a_ovf, 0); chk("rst_cnt", a_cnt, 0);
    chk("rst_hlt", a_hlt, 0);

    // Sums 5,12,10 with priming at zero
    drive(1, 8'd5);
    chk("t1_d0", a_d, 8'h05); chk("t1_dv0", a_dv, 1); chk("t1_b0", a_brw, 0);
    drive(1, 8'd12);
    chk("t1_d1", a_d, 8'h07); chk("t1_dv1", a_dv, 1); chk("t1_b1", a_brw, 0);
    drive(1, 8'd10);
    chk("t1_d2", a_d, 8'hFE); chk("t1_dv2", a_dv, 1); chk("t1_b2", a_brw, 1);
    chk("t1_ovf", a_ovf, 0);
    drive(0, 8'd0);
    chk("t1_dv_off", a_dv, 0); chk("t1_cnt", a_cnt, 3);

    // Non-priming variant: first sample only loads prev
    do_reset();
    drive(1, 8'd20);
    chk("t2_dv0", b_dv, 0); chk("t2_prev0", b_prev, 8'd20); chk("t2_cnt0", b_cnt, 0);
    drive(1, 8'd25);
    chk("t2_d", b_d, 8'h05); chk("t2_dv1", b_dv, 1);
    chk("t2_prev1", b_prev, 8'd25); chk("t2_cnt1", b_cnt, 1);

    // +100 then -100: signed overflow halts
    do_reset();
    drive(1, 8'h64);
    chk("t3_d0", a_d, 8'h64); chk("t3_ovf0", a_ovf, 0);
    drive(1, 8'h9C);
    chk("t3_d1", a_d, 8'h38); chk("t3_ovf1", a_ovf, 1); chk("t3_hlt", a_hlt, 1);
    chk("t3_brw", a_brw, 0);
    drive(1, 8'h11);
    chk("t3_frz_dv", a_dv, 0);    chk("t3_frz_d", a_d, 8'h38);
    chk("t3_frz_prev", a_prev, 8'h9C); chk("t3_frz_ovf", a_ovf, 1);
    chk("t3_frz_cnt", a_cnt, 2);  chk("t3_frz_hlt", a_hlt, 1);
    drive(1, 8'h22);
    chk("t3_frz2_dv", a_dv, 0);   chk("t3_frz2_prev", a_prev, 8'h9C);

    // Clear beats in_valid while halted
    clear = 1'b1;
    drive(1, 8'h33);
    clear = 1'b0;
    chk("t4_hlt", a_hlt, 0);  chk("t4_prev", a_prev, 0); chk("t4_cnt", a_cnt, 0);
    chk("t4_ovf", a_ovf, 0);  chk("t4_dv", a_dv, 0);     chk("t4_dhold", a_d, 8'h38);
    drive(1, 8'h02);
    chk("t4_d_after", a_d, 8'h02); chk("t4_cnt_after", a_cnt, 1);

    // Wrap-around: 0x7F -> 0x80 gives +1 with overflow
    do_reset();
    drive(1, 8'h7F);
    drive(1, 8'h80);
    chk("wrap_d", a_d, 8'h01); chk("wrap_ovf", a_ovf, 1); chk("wrap_hlt", a_hlt, 1);

    // Asynchronous reset mid-stream
    do_reset();
    drive(1, 8'h20);
    drive(1, 8'h40);
    in_valid = 1'b0;
    chk("t5_cnt_pre", a_cnt, 2); chk("t5_prev_pre", a_prev, 8'h40);
    @(negedge gclk);
    #1;
    grst_n = 1'b0;
    #1;
    chk("t5_d", a_d, 0);     chk("t5_dv", a_dv, 0);    chk("t5_prev", a_prev, 0);
    chk("t5_brw", a_brw, 0); chk("t5_ovf", a_ovf, 0);  chk("t5_cnt", a_cnt, 0);
    chk("t5_hlt", a_hlt, 0);
    grst_n = 1'b1;
    step();
    drive(1, 8'h07);
    chk("t5_prime_d", a_d, 8'h07); chk("t5_prime_cnt", a_cnt, 1);

    // Gapped valid pattern; count saturation on the 2-bit counter
    do_reset();
    drive(1, 8'd3);
    chk("t6_dv0", a_dv, 1); chk("t6_d0", a_d, 8'h03);
    drive(0, 8'd0);
    chk("t6_dv1", a_dv, 0); chk("t6_prev1", a_prev, 8'd3);
    drive(0, 8'd0);
    chk("t6_dv2", a_dv, 0); chk("t6_prev2", a_prev, 8'd3);
    drive(1, 8'd9);
    chk("t6_dv3", a_dv, 1); chk("t6_d3", a_d, 8'h06);
    chk("t6_c2_cnt2", c_cnt, 2);
    drive(1, 8'd10);
    chk("t6_c2_cnt3", c_cnt, 3);
    drive(1, 8'd11);
    drive(1, 8'd12);
    chk("t6_c2_sat5", c_cnt, 3); chk("t6_a_cnt5", a_cnt, 5);
    drive(1, 8'd13);
    chk("t6_c2_sat6", c_cnt, 3);
    drive(0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
